// File: rtl/gcd_fsm_core.sv
// Multi-cycle GCD engine: operands load serially on data_in, then the larger
// register is reduced by the smaller until both registers match.
module gcd_fsm_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_A  = 3'd1;
    localparam logic [2:0] LOAD_B  = 3'd2;
    localparam logic [2:0] COMPUTE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_A;
            end
            LOAD_A: begin
                a_d     = data_in;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                b_d     = data_in;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                // Zero guard must precede the subtract cases, otherwise a zero
                // operand would never converge.
                if (a_q == b_q) begin
                    state_d = DONE;
                end else if ((a_q == '0) || (b_q == '0)) begin
                    a_d     = a_q | b_q;
                    state_d = DONE;
                end else if (a_q < b_q) begin
                    b_d = b_q - a_q;
                end else begin
                    a_d = a_q - b_q;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign done   = (state_q == DONE);
    assign result = a_q;

endmodule

// File: tb/tb_gcd_fsm_core.sv
// Directed bench for gcd_fsm_core: a Euclid reference model fills a scoreboard
// queue at operand load, and entries are retired when done rises.
module tb_gcd_fsm_core;

    localparam int WIDTH = 16;
    localparam int BOUND = 70000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic [WIDTH-1:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [WIDTH-1:0] sb[$];

    gcd_fsm_core #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data_in(data_in),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] p, q, t;
        p = x;
        q = y;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes the DUT is idle; leaves start high with the DUT in DONE.
    task automatic run_gcd(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int exp_lat);
        int n;
        logic [WIDTH-1:0] e;
        start = 1'b1;
        tick();
        check({tag, "_accept_done"}, {31'd0, done}, 32'd0);
        data_in = a;
        tick();
        data_in = b;
        tick();
        sb.push_back(ref_gcd(a, b));
        n = 0;
        while (done !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, n, exp_lat);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, {16'd0, result}, {16'd0, e});
        end
    endtask

    task automatic release_start(input string tag, input logic [WIDTH-1:0] exp_res);
        start = 1'b0;
        tick();
        check({tag, "_release_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_result"}, {16'd0, result}, {16'd0, exp_res});
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #3;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;

        // Nominal 143/78: six subtractions then the equality edge
        run_gcd("nominal", 16'd143, 16'd78, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_done", {31'd0, done}, 32'd1);
            check("hold_result", {16'd0, result}, 32'd13);
        end
        release_start("nominal", 16'd13);
        repeat (3) tick();
        check("idle_no_start", {31'd0, done}, 32'd0);

        run_gcd("equal", 16'd21, 16'd21, 1);
        release_start("equal", 16'd21);
        run_gcd("zero_a", 16'd0, 16'd48, 1);
        release_start("zero_a", 16'd48);
        run_gcd("zero_both", 16'd0, 16'd0, 1);
        release_start("zero_both", 16'd0);
        run_gcd("max_one", 16'd65535, 16'd1, 65535);
        release_start("max_one", 16'd1);
        run_gcd("max_max", 16'd65535, 16'd65535, 1);
        release_start("max_max", 16'd65535);
        run_gcd("restart", 16'd12, 16'd18, 3);
        release_start("restart", 16'd6);

        // Abort a computation with an asynchronous reset between edges
        start = 1'b1;
        tick();
        data_in = 16'd143;
        tick();
        data_in = 16'd78;
        tick();
        sb.push_back(ref_gcd(16'd143, 16'd78));
        tick();
        tick();
        check("midcomp_done", {31'd0, done}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_done", {31'd0, done}, 32'd0);
        check("async_result", {16'd0, result}, 32'd0);
        sb.delete();
        start = 1'b0;
        #3;
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_reset_done", {31'd0, done}, 32'd0);
        check("post_reset_result", {16'd0, result}, 32'd0);

        run_gcd("after_reset", 16'd12, 16'd18, 3);
        release_start("after_reset", 16'd6);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
